// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//   Writeback stage that sits directly behind the ALU. It records the
//   destination tag of each op issued to the ALU. It pairs each tag, in order,
//   with the ALU's registered result. It buffers the pairs and hands them to
//   the register file over a valid/ready handshake. The ALU cannot stall, so
//   issue_ready throttles the issue stage.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   issue_en/rd/we     op issued to the ALU this cycle and its destination tag
//   issue_ready        stage can take another issue (credit available)
//   alu_valid/data     registered ALU result
//   wb_valid/ready     handshake toward the register file
//   wb_rd/we/data      head entry; all zero while wb_valid is low
//   protocol_err       sticky flag: ALU result arrived with no pending tag
// ---------------------------------------------------------------------------
module alu_writeback #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int RAW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_en,
  input  logic [RAW-1:0]   issue_rd,
  input  logic             issue_we,
  output logic             issue_ready,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_data,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RAW-1:0]   wb_rd,
  output logic             wb_we,
  output logic [WIDTH-1:0] wb_data,
  output logic             protocol_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Control state (reset)
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [PW-1:0] twp_q, twp_d, trp_q, trp_d;
  logic [PW-1:0] rwp_q, rwp_d, rrp_q, rrp_d;
  logic          perr_q, perr_d;

  // Storage (no reset; occupancy counters decide what is valid)
  logic [RAW-1:0]   tag_rd_q   [DEPTH];
  logic             tag_we_q   [DEPTH];
  logic [RAW-1:0]   res_rd_q   [DEPTH];
  logic             res_we_q   [DEPTH];
  logic [WIDTH-1:0] res_data_q [DEPTH];

  logic issue_fire;
  logic pair;
  logic retire;

  // Credit is decoded from registered cnt only, so a retire in this cycle
  // does not free a slot until the next cycle.
  assign issue_ready = (cnt_q < CW'(DEPTH));
  assign issue_fire  = issue_en & issue_ready;
  // A tag pushed this cycle is not yet visible, so pairing uses tcnt_q.
  assign pair        = alu_valid & (tcnt_q != '0);
  assign wb_valid    = (rcnt_q != '0);
  assign retire      = wb_valid & wb_ready;

  always_comb begin
    cnt_d  = cnt_q;
    tcnt_d = tcnt_q;
    rcnt_d = rcnt_q;
    twp_d  = twp_q;
    trp_d  = trp_q;
    rwp_d  = rwp_q;
    rrp_d  = rrp_q;
    perr_d = perr_q;

    case ({issue_fire, retire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({issue_fire, pair})
      2'b10:   tcnt_d = tcnt_q + CW'(1);
      2'b01:   tcnt_d = tcnt_q - CW'(1);
      default: tcnt_d = tcnt_q;
    endcase

    case ({pair, retire})
      2'b10:   rcnt_d = rcnt_q + CW'(1);
      2'b01:   rcnt_d = rcnt_q - CW'(1);
      default: rcnt_d = rcnt_q;
    endcase

    // Pointers wrap naturally: DEPTH is a power of two.
    if (issue_fire) twp_d = twp_q + PW'(1);
    if (pair) begin
      trp_d = trp_q + PW'(1);
      rwp_d = rwp_q + PW'(1);
    end
    if (retire) rrp_d = rrp_q + PW'(1);

    // Orphan result: dropped and flagged until reset.
    if (alu_valid && (tcnt_q == '0)) perr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tcnt_q <= '0;
      rcnt_q <= '0;
      twp_q  <= '0;
      trp_q  <= '0;
      rwp_q  <= '0;
      rrp_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tcnt_q <= tcnt_d;
      rcnt_q <= rcnt_d;
      twp_q  <= twp_d;
      trp_q  <= trp_d;
      rwp_q  <= rwp_d;
      rrp_q  <= rrp_d;
      perr_q <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      tag_rd_q[twp_q] <= issue_rd;
      tag_we_q[twp_q] <= issue_we;
    end
    if (pair) begin
      res_rd_q[rwp_q]   <= tag_rd_q[trp_q];
      res_we_q[rwp_q]   <= tag_we_q[trp_q];
      res_data_q[rwp_q] <= alu_data;
    end
  end

  // The head entry is shown first-word-fall-through and forced to zero when
  // the FIFO is empty. Writes to x0 are still handshaken, but with we dropped.
  assign wb_rd        = wb_valid ? res_rd_q[rrp_q]   : '0;
  assign wb_data      = wb_valid ? res_data_q[rrp_q] : '0;
  assign wb_we        = wb_valid & res_we_q[rrp_q] & (res_rd_q[rrp_q] != '0);
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clk;
  logic        rst;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        issue_we;
  logic        issue_ready;
  logic        alu_valid;
  logic [31:0] alu_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        protocol_err;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  alu_writeback #(.WIDTH(32), .DEPTH(4), .RAW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_en     (issue_en),
    .issue_rd     (issue_rd),
    .issue_we     (issue_we),
    .issue_ready  (issue_ready),
    .alu_valid    (alu_valid),
    .alu_data     (alu_data),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we),
    .wb_data      (wb_data),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic ie, input logic [4:0] rd, input logic we,
                     input logic av, input logic [31:0] d, input logic wr);
    issue_en  = ie;
    issue_rd  = rd;
    issue_we  = we;
    alu_valid = av;
    alu_data  = d;
    wb_ready  = wr;
  endtask

  // Expected register-file view of a paired result; x0 never gets written.
  task automatic expect_res(input logic [4:0] rd, input logic we, input logic [31:0] d);
    exp_t e;
    e.rd   = rd;
    e.we   = we && (rd != 5'd0);
    e.data = d;
    sbq.push_back(e);
  endtask

  // Scoreboard: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected observed_rd=%0h observed_data=%0h expected=none", wb_rd, wb_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_rd", 32'(wb_rd), 32'(mon_e.rd));
        chk("sb_we", 32'(wb_we), 32'(mon_e.we));
        chk("sb_data", wb_data, mon_e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    set(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    // Reset state
    chk("rst_issue_ready", 32'(issue_ready), 1);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_wb_we", 32'(wb_we), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_perr", 32'(protocol_err), 0);
    rst = 1'b0;
    tick();

    // Test 1: single op, one-cycle latency
    set(1, 5, 1, 0, 0, 1);
    tick();
    set(0, 0, 0, 1, 32'h12345678, 1);
    expect_res(5, 1, 32'h12345678);
    tick();
    chk("t1_wb_valid", 32'(wb_valid), 1);
    chk("t1_wb_rd", 32'(wb_rd), 5);
    chk("t1_wb_we", 32'(wb_we), 1);
    chk("t1_wb_data", wb_data, 32'h12345678);
    set(0, 0, 0, 0, 0, 1);
    tick();
    chk("t1_wb_valid_after", 32'(wb_valid), 0);
    chk("t1_wb_data_after", wb_data, 0);
    chk("t1_issue_ready", 32'(issue_ready), 1);

    // Test 2: write to x0 is presented with we dropped
    set(1, 0, 1, 0, 0, 1);
    tick();
    set(0, 0, 0, 1, 32'hFFFFFFFF, 1);
    expect_res(0, 1, 32'hFFFFFFFF);
    tick();
    chk("t2_wb_valid", 32'(wb_valid), 1);
    chk("t2_wb_we", 32'(wb_we), 0);
    set(0, 0, 0, 0, 0, 1);
    tick();
    chk("t2_retired", 32'(wb_valid), 0);

    // Test 3: fill to DEPTH with writeback stalled
    set(1, 1, 1, 0, 0, 0);
    tick();
    set(1, 2, 1, 1, 32'h11, 0); expect_res(1, 1, 32'h11);
    tick();
    set(1, 3, 1, 1, 32'h22, 0); expect_res(2, 1, 32'h22);
    tick();
    set(1, 4, 1, 1, 32'h33, 0); expect_res(3, 1, 32'h33);
    tick();
    chk("t3_full_ready", 32'(issue_ready), 0);
    set(1, 9, 1, 1, 32'h44, 0); expect_res(4, 1, 32'h44);
    tick();
    chk("t3_still_full", 32'(issue_ready), 0);
    chk("t3_head_rd", 32'(wb_rd), 1);
    chk("t3_head_data", wb_data, 32'h11);
    set(0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_hold_valid", 32'(wb_valid), 1);
    chk("t3_hold_rd", 32'(wb_rd), 1);
    chk("t3_hold_data", wb_data, 32'h11);
    set(0, 0, 0, 0, 0, 1);
    repeat (4) tick();
    chk("t3_drained", 32'(wb_valid), 0);
    chk("t3_ready_back", 32'(issue_ready), 1);

    // Test 4: issue and retire in the same cycle keep the credit count
    set(1, 10, 1, 0, 0, 0);
    tick();
    set(1, 11, 1, 1, 32'hA0, 0); expect_res(10, 1, 32'hA0);
    tick();
    set(0, 0, 0, 1, 32'hB0, 0); expect_res(11, 1, 32'hB0);
    tick();
    set(1, 7, 1, 0, 0, 1);
    tick();
    chk("t4_ready_cnt2", 32'(issue_ready), 1);
    chk("t4_head_rd", 32'(wb_rd), 11);
    set(1, 12, 1, 1, 32'h70, 0); expect_res(7, 1, 32'h70);
    tick();
    chk("t4_ready_cnt3", 32'(issue_ready), 1);
    set(1, 13, 1, 1, 32'hC0, 0); expect_res(12, 1, 32'hC0);
    tick();
    chk("t4_ready_cnt4", 32'(issue_ready), 0);
    set(0, 0, 0, 1, 32'hD0, 1); expect_res(13, 1, 32'hD0);
    tick();
    set(0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    chk("t4_drained", 32'(wb_valid), 0);
    chk("t4_ready_back", 32'(issue_ready), 1);

    // Test 5: orphan ALU result
    chk("t5_perr_before", 32'(protocol_err), 0);
    set(0, 0, 0, 1, 32'hDEAD, 1);
    tick();
    chk("t5_perr_set", 32'(protocol_err), 1);
    chk("t5_no_entry", 32'(wb_valid), 0);
    set(1, 3, 1, 0, 0, 1);
    tick();
    set(0, 0, 0, 1, 32'h33, 1); expect_res(3, 1, 32'h33);
    tick();
    chk("t5_normal_valid", 32'(wb_valid), 1);
    set(0, 0, 0, 0, 0, 1);
    tick();
    chk("t5_perr_sticky", 32'(protocol_err), 1);
    chk("t5_drained", 32'(wb_valid), 0);

    // Test 6: asynchronous reset with entries buffered
    set(1, 20, 1, 0, 0, 0);
    tick();
    set(1, 21, 1, 1, 32'h200, 0); expect_res(20, 1, 32'h200);
    tick();
    set(1, 22, 1, 1, 32'h210, 0); expect_res(21, 1, 32'h210);
    tick();
    set(0, 0, 0, 1, 32'h220, 0); expect_res(22, 1, 32'h220);
    tick();
    chk("t6_buffered", 32'(wb_valid), 1);
    set(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_wb_valid", 32'(wb_valid), 0);
    chk("t6_rst_wb_data", wb_data, 0);
    chk("t6_rst_wb_rd", 32'(wb_rd), 0);
    chk("t6_rst_issue_ready", 32'(issue_ready), 1);
    chk("t6_rst_perr", 32'(protocol_err), 0);
    sbq.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_empty", 32'(wb_valid), 0);
    set(1, 6, 1, 0, 0, 1);
    tick();
    set(0, 0, 0, 1, 32'h12345678, 1); expect_res(6, 1, 32'h12345678);
    tick();
    chk("t6_post_valid", 32'(wb_valid), 1);
    chk("t6_post_rd", 32'(wb_rd), 6);
    chk("t6_post_data", wb_data, 32'h12345678);
    set(0, 0, 0, 0, 0, 1);
    tick();
    chk("t6_post_drained", 32'(wb_valid), 0);
    chk("t6_post_ready", 32'(issue_ready), 1);

    // Every expected result must have been delivered.
    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
